// File: rtl/sp_ram_burst_reader.sv
// ============================================================================
// Module   : sp_ram_burst_reader
// Brief    : Burst read master for sp_ram_v1 with credit-limited issue and a
//            return buffer feeding a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sp_ram_burst_reader #(
   parameter int AW      = 4,
   parameter int DW      = 4,
   parameter int LATENCY = 2,
   parameter int DEPTH   = LATENCY + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last
);

   localparam int c_CW = $clog2(DEPTH + 1);
   localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [AW:0]       r_len;
   logic [AW:0]       r_issued;
   logic [AW:0]       r_beats;
   logic [LATENCY-1:0] r_pipe;
   logic [DW-1:0]     r_mem [DEPTH];
   logic [c_PW-1:0]   r_wptr;
   logic [c_PW-1:0]   r_rptr;
   logic [c_CW-1:0]   r_count;
   logic [c_CW-1:0]   w_inflight;
   logic [c_CW:0]     w_outstanding;
   logic              w_credit;
   logic              w_issue;
   logic              w_beat;
   logic              w_capture;

   assign ram_we  = 1'b0;
   assign ram_din = '0;

   assign m_valid = (r_count != '0);
   assign m_data  = r_mem[r_rptr];
   assign m_last  = m_valid && (r_beats == r_len - 1'b1);

   assign w_beat    = m_valid && m_ready;
   assign w_capture = r_pipe[LATENCY-1];

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         w_inflight = w_inflight + c_CW'(r_pipe[i]);
      end
   end

   // A beat this cycle frees a slot, which keeps a full-rate burst from stalling.
   assign w_outstanding = {1'b0, r_count} + {1'b0, w_inflight};
   assign w_credit      = (w_outstanding - {{c_CW{1'b0}}, w_beat}) < (c_CW + 1)'(DEPTH);
   assign w_issue       = (r_state == S_ISSUE) && w_credit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = (r_state != S_IDLE);
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (len == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_issue && (r_issued == r_len - 1'b1)) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_beat && m_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len    <= '0;
         r_issued <= '0;
         r_beats  <= '0;
         ram_addr <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_len    <= len;
            r_issued <= '0;
            r_beats  <= '0;
            ram_addr <= base_addr;
         end else begin
            if (w_issue) begin
               ram_addr <= ram_addr + 1'b1;
               r_issued <= r_issued + 1'b1;
            end
            if (w_beat) begin
               r_beats <= r_beats + 1'b1;
            end
         end
      end
   end

   // One tag per issued read; the tag leaving the last stage marks valid ram_dout.
   generate
      if (LATENCY == 1) begin : g_pipe_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pipe <= '0;
            end else begin
               r_pipe <= w_issue;
            end
         end
      end else begin : g_pipe_multi
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pipe <= '0;
            end else begin
               r_pipe <= {r_pipe[LATENCY-2:0], w_issue};
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_capture) begin
            r_mem[r_wptr] <= ram_dout;
            r_wptr        <= (r_wptr == c_PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_beat) begin
            r_rptr <= (r_rptr == c_PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
         end
         r_count <= r_count + c_CW'(w_capture) - c_CW'(w_beat);
      end
   end

endmodule

`default_nettype wire
